spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI responder for the far end of the bus driven by our SPI master controller.
- Oversamples sck/ss/mosi in the clk domain, supports all four CPOL/CPHA modes and 1–16-bit frames, MSB first.
- Presents a one-word TX holding buffer (valid/ready) and an RX word with a one-cycle valid strobe to the local CPU side.
- Drives miso with an output-enable for a tri-state pad.

Parameters:
SYNC_STAGES, 2, synchronizer depth for sck, ss, mosi (min 2)
MAX_LEN, 16, shift register width; frame length is xfer_len+1 ≤ MAX_LEN

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
cpol  input  1  sck idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
xfer_len  input  4  frame length minus one (0 → 1 bit, 15 → 16 bits)
sck  input  1  SPI clock from master (asynchronous)
ss  input  1  slave select, active-low (asynchronous)
mosi  input  1  master-out data (asynchronous)
miso  output  1  slave-out data
miso_oe  output  1  miso pad enable; 1 only while selected
tx_data  input  16  next word to transmit, right-justified
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding buffer empty
rx_data  output  16  last received word, right-justified, upper bits zero
rx_valid  output  1  one-cycle strobe: rx_data updated
busy  output  1  frame in progress
underrun  output  1  one-cycle strobe: frame started with empty holding buffer
frame_err  output  1  one-cycle strobe: ss deasserted before last bit sampled

Behaviour:
- Reset values (all sync to clk): miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0, state=IDLE, holding buffer empty.
- Synchronizers: sck, ss, mosi each pass through SYNC_STAGES flops.
  - One extra sck flop gives edge detection; edges are relative to the synchronized signals.
  - sck high and low times must each be ≥ SYNC_STAGES+2 clk periods.
- Edge classes:
  - leading = synchronized sck leaves cpol level; trailing = returns to it.
  - sample edge = leading if cpha=0, else trailing; shift edge = the other one.
- TX handshake:
  - tx_data is captured into the holding buffer on tx_valid && tx_ready; tx_ready then goes 0 the next cycle.
  - The buffer empties, and tx_ready returns to 1, in the cycle the shift register loads from it.
- State machine:
  - IDLE:
    - miso_oe=0, busy=0.
    - On synchronized ss falling: latch cpol/cpha/xfer_len for the frame; bit counter=0.
    - Load the shift register with the holding buffer left-aligned so bit xfer_len sits at the MSB. If the buffer is empty, load 0 and pulse underrun.
    - → ACTIVE.
  - ACTIVE:
    - miso_oe=1, busy=1, miso = shift register MSB.
    - First output bit is valid from the ACTIVE entry cycle; this covers cpha=0.
    - Sample edge: shift synchronized mosi into the rx shift register; counter+1.
    - Shift edge: shift TX register left, except a cpha=1 frame's first leading edge, which only marks the start (MSB is already presented).
    - When counter reaches xfer_len+1 on a sample edge: next cycle rx_data ← received bits (right-justified), rx_valid=1 for one cycle → DONE.
    - ss rising in ACTIVE: pulse frame_err, rx_data unchanged, no rx_valid → IDLE.
  - DONE:
    - busy=1, miso_oe=1, miso holds the last value; further sck edges are ignored.
    - On ss rising → IDLE. No frame_err here.
- Mode inputs changing mid-frame have no effect until the next frame.
- ss falling and a sck edge in the same synchronized cycle: the ss event is processed first; the sck edge is ignored.
- tx_valid during a frame fills the holding buffer for the next frame only.
- rst mid-frame: immediate return to reset values; the buffer is discarded.

Test Plan:
- Mode 0, xfer_len=7, tx_data=0xA5 loaded before ss falls; master sends 0x3C → miso shows 1,0,1,0,0,1,0,1 on the 8 rising edges; rx_data=0x003C, rx_valid one pulse; tx_ready returns to 1 at frame start.
- Mode 3 (cpol=1, cpha=1), xfer_len=15, tx_data=0xBEEF; master sends 0x1234 → master captures 0xBEEF; rx_data=0x1234; no underrun or frame_err.
- Modes 1 and 2, xfer_len=0, tx_data=0x1; master sends 0 → single bit exchanged; rx_data=0x0000, rx_valid pulses once per frame.
- No tx_valid before the frame, mode 0, 8 bits → underrun pulses once at frame start; miso=0 for all bits; rx completes normally.
- ss raised after 4 of 8 sample edges → frame_err pulses once; rx_valid stays 0; rx_data keeps its previous value; next full frame succeeds.
- rst asserted mid-frame with the holding buffer full → next cycle miso_oe=0, busy=0, tx_ready=1; extra sck edges while in DONE do not alter miso or rx_data.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder, all CPOL/CPHA modes, 1-16 bit MSB-first frames,
// one-word TX holding buffer and RX word strobe on the clk side.
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [3:0]  xfer_len,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        underrun,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic sck_prev_q, sck_prev_d, ss_prev_q, ss_prev_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [3:0] len_q, len_d;
  logic [4:0] cnt_q, cnt_d;
  logic [MAX_LEN-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [15:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic full_q, full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic sck_s, ss_s, mosi_s, sck_edge, leading, sample_e, shift_e, ss_fall, ss_rise;
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_s = sck_sync_q[SYNC_STAGES-1];
    ss_s = ss_sync_q[SYNC_STAGES-1];
    mosi_s = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d = sck_s;
    ss_prev_d = ss_s;
    sck_edge = sck_s ^ sck_prev_q;
    leading = sck_edge & (sck_s ^ cpol_q);
    sample_e = sck_edge & (leading ^ cpha_q);
    shift_e = sck_edge & ~(leading ^ cpha_q);
    ss_fall = ~ss_s & ss_prev_q;
    ss_rise = ss_s & ~ss_prev_q;
  end
  always_comb begin
    state_d = state_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    len_d = len_q;
    cnt_d = cnt_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    hold_d = hold_q;
    full_d = full_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (ss_fall) begin
        cpol_d = cpol;
        cpha_d = cpha;
        len_d = xfer_len;
        cnt_d = '0;
        rx_sr_d = '0;
        tx_sr_d = full_q ? MAX_LEN'(hold_q) << (MAX_LEN - 1 - int'(xfer_len)) : '0;
        underrun_d = ~full_q;
        full_d = 1'b0;
        state_d = ACTIVE;
      end
      ACTIVE: if (ss_rise) begin
        frame_err_d = 1'b1;
        state_d = IDLE;
      end else begin
        if (sample_e) begin
          rx_sr_d = {rx_sr_q[MAX_LEN-2:0], mosi_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == {1'b0, len_q}) begin
            rx_data_d = 16'(rx_sr_d);
            rx_valid_d = 1'b1;
            state_d = DONE;
          end
        end
        // a cpha=1 frame's first leading edge only marks the start; the MSB is already out
        if (shift_e && !(cpha_q && cnt_q == 5'd0)) tx_sr_d = tx_sr_q << 1;
      end
      DONE: if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sck_sync_q <= '0;
      ss_sync_q <= '1;
      mosi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      ss_prev_q <= 1'b1;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_sync_q <= sck_sync_d;
      ss_sync_q <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q <= sck_prev_d;
      ss_prev_q <= ss_prev_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      hold_q <= hold_d;
      full_q <= full_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign miso = (state_q != IDLE) & tx_sr_q[MAX_LEN-1];
  assign miso_oe = state_q != IDLE;
  assign busy = state_q != IDLE;
  assign tx_ready = ~full_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives SPI frames as a master and checks against a word-level model.
module tb_spi_slave;
  logic clk = 1'b0, rst = 1'b1, cpol = 1'b0, cpha = 1'b0, sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic [3:0] xfer_len = '0;
  logic [15:0] tx_data = '0, rx_data;
  logic tx_valid = 1'b0, tx_ready, miso, miso_oe, rx_valid, busy, underrun, frame_err;
  int checks = 0, failures = 0, rxv_n = 0, ur_n = 0, fe_n = 0;
  logic [15:0] got, tw, mw, prev_rx, m_hold;
  logic hold_miso;
  int rv0, ur0, fe0;

  spi_slave dut (.clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .xfer_len(xfer_len), .sck(sck),
    .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .underrun(underrun),
    .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) rxv_n++;
    if (underrun) ur_n++;
    if (frame_err) fe_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mask(input int len);
    logic [16:0] m;
    m = (17'd1 << (len + 1)) - 17'd1;
    return m[15:0];
  endfunction

  task automatic load(input logic [15:0] w);
    tx_data = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("tx_ready_low", 32'(tx_ready), 32'd0);
  endtask

  // master side: sends nsend bits of w (MSB of the len+1 bit frame first), collects miso into got
  task automatic run_frame(input logic p, input logic h, input int len, input int nsend,
                           input logic [15:0] w, input logic raise);
    cpol = p;
    cpha = h;
    xfer_len = 4'(len);
    sck = p;
    mosi = 1'b0;
    tick(6);
    ss = 1'b0;
    tick(6);
    chk("busy_start", 32'(busy), 32'd1);
    chk("oe_start", 32'(miso_oe), 32'd1);
    chk("tx_ready_start", 32'(tx_ready), 32'd1);
    got = '0;
    for (int i = 0; i < nsend; i++) begin
      if (!h) begin
        mosi = w[len-i];
        tick(4);
        got = {got[14:0], miso};
        sck = ~p;
        tick(8);
        sck = p;
        tick(4);
      end else begin
        tick(4);
        sck = ~p;
        tick(2);
        mosi = w[len-i];
        tick(6);
        got = {got[14:0], miso};
        sck = p;
        tick(4);
      end
    end
    if (raise) begin
      ss = 1'b1;
      tick(8);
      chk("busy_end", 32'(busy), 32'd0);
    end
  endtask

  // one complete frame checked against the word-level model
  task automatic model_frame(input string tag, input logic p, input logic h, input int len,
                             input logic ld, input logic [15:0] t, input logic [15:0] w);
    if (ld) load(t);
    rv0 = rxv_n;
    ur0 = ur_n;
    fe0 = fe_n;
    run_frame(p, h, len, len + 1, w, 1'b1);
    chk({tag, "_miso_word"}, 32'(got), 32'(ld ? t & mask(len) : 16'h0));
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(w & mask(len)));
    chk({tag, "_rx_valid_n"}, 32'(rxv_n - rv0), 32'd1);
    chk({tag, "_underrun_n"}, 32'(ur_n - ur0), ld ? 32'd0 : 32'd1);
    chk({tag, "_frame_err_n"}, 32'(fe_n - fe0), 32'd0);
  endtask

  initial begin
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_strobes", 32'({rx_valid, underrun, frame_err}), 32'd0);

    model_frame("mode0", 1'b0, 1'b0, 7, 1'b1, 16'h00A5, 16'h003C);
    model_frame("mode3", 1'b1, 1'b1, 15, 1'b1, 16'hBEEF, 16'h1234);
    model_frame("mode1", 1'b0, 1'b1, 0, 1'b1, 16'h0001, 16'h0000);
    model_frame("mode2", 1'b1, 1'b0, 0, 1'b1, 16'h0001, 16'h0000);
    model_frame("underrun", 1'b0, 1'b0, 7, 1'b0, 16'h0000, 16'($urandom));

    load(16'h0055);
    prev_rx = rx_data;
    rv0 = rxv_n;
    fe0 = fe_n;
    run_frame(1'b0, 1'b0, 7, 4, 16'h00FF, 1'b1);
    chk("abort_frame_err_n", 32'(fe_n - fe0), 32'd1);
    chk("abort_rx_valid_n", 32'(rxv_n - rv0), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'(prev_rx));
    model_frame("after_abort", 1'b0, 1'b0, 7, 1'b1, 16'h0096, 16'h00C3);

    for (int k = 0; k < 8; k++)
      model_frame("rand", 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                  16'($urandom), 16'($urandom));

    tw = 16'($urandom);
    mw = 16'($urandom);
    load(tw);
    fe0 = fe_n;
    run_frame(1'b0, 1'b0, 11, 12, mw, 1'b0);
    chk("done_word", 32'(got), 32'(tw & mask(11)));
    hold_miso = miso;
    m_hold = rx_data;
    for (int i = 0; i < 4; i++) begin
      sck = ~sck;
      tick(8);
    end
    chk("done_miso_hold", 32'(miso), 32'(hold_miso));
    chk("done_rx_hold", 32'(m_hold), 32'(mw & mask(11)));
    chk("done_rx_data", 32'(rx_data), 32'(mw & mask(11)));
    chk("done_busy", 32'(busy), 32'd1);
    ss = 1'b1;
    tick(8);
    chk("done_no_frame_err", 32'(fe_n - fe0), 32'd0);

    cpol = 1'b0;
    cpha = 1'b0;
    xfer_len = 4'd7;
    sck = 1'b0;
    tick(4);
    ss = 1'b0;
    tick(6);
    sck = 1'b1;
    tick(8);
    sck = 1'b0;
    tick(8);
    load(16'h1234);
    rst = 1'b1;
    ss = 1'b1;
    tick(1);
    chk("rst_mid_oe", 32'(miso_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    tick(3);
    rst = 1'b0;
    tick(2);
    model_frame("post_rst", 1'b0, 1'b0, 7, 1'b0, 16'h0000, 16'h005A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
